// File: rtl/uart_hex_tx_if.sv
// Byte-strobe input, host flow control and serial/status outputs of the
// hex-rendering UART transmitter.
interface uart_hex_tx_if;
  logic [7:0] din;
  logic       din_valid;
  logic       host_rdy_n;
  logic       txd;
  logic       full;
  logic       overflow;
  logic       busy;

  modport master (
    output din, din_valid, host_rdy_n,
    input  txd, full, overflow, busy
  );

  modport slave (
    input  din, din_valid, host_rdy_n,
    output txd, full, overflow, busy
  );
endinterface

// File: rtl/uart_hex_tx.sv
// Buffers strobed bytes in a FIFO and sends each as two uppercase ASCII hex
// characters (plus optional separator) on an 8N1 line with host flow control.
module uart_hex_tx #(
  parameter int         CLK_HZ     = 100_000_000,
  parameter int         BAUD       = 115200,
  parameter int         FIFO_DEPTH = 16,
  parameter bit         SEP_EN     = 1'b1,
  parameter logic [7:0] SEP_CHAR   = 8'h20
) (
  input logic         clk,
  input logic         rst,
  uart_hex_tx_if.slave bus
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int NW  = PW + 1;

  typedef enum logic [2:0] {IDLE, POP, START, DATA, STOP} state_t;

  logic          sync1_q, sync1_d, sync2_q, sync2_d;
  logic          rdy_s;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NW-1:0] count_q, count_d;
  logic          full_q, full_d, overflow_q, overflow_d;
  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    char_q, char_d;
  logic [7:0]    shift_q, shift_d, byte_q, byte_d;
  logic          txd_q, txd_d;
  logic          pop, wr, bit_end, fifo_nempty;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign rdy_s       = sync2_q;
  assign fifo_nempty = (count_q != '0);

  always_comb begin
    sync1_d    = bus.host_rdy_n;
    sync2_d    = sync1_q;
    pop        = (state_q == POP);
    wr         = bus.din_valid && (!full_q || pop);
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (wr) begin
      mem_d[wr_ptr_q] = bus.din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d    = count_q + NW'(wr) - NW'(pop);
    full_d     = (count_d == NW'(FIFO_DEPTH));
    overflow_d = bus.din_valid && full_q && !pop;
  end

  // Flow control is only consulted in IDLE and after a byte's final stop bit.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    char_d  = char_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    bit_end = (baud_q == CW'(DIV - 1));
    case (state_q)
      IDLE: begin
        if (fifo_nempty && !rdy_s) state_d = POP;
      end
      POP: begin
        byte_d  = mem_q[rd_ptr_q];
        shift_d = hex_char(mem_q[rd_ptr_q][7:4]);
        char_d  = 2'd0;
        baud_d  = '0;
        state_d = START;
      end
      START: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (char_q == 2'd0) begin
            shift_d = hex_char(byte_q[3:0]);
            char_d  = 2'd1;
            state_d = START;
          end else if ((char_q == 2'd1) && SEP_EN) begin
            shift_d = SEP_CHAR;
            char_d  = 2'd2;
            state_d = START;
          end else if (fifo_nempty && !rdy_s) begin
            state_d = POP;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // txd is registered from the next state so the line never glitches.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= 3'd0;
      char_q     <= 2'd0;
      shift_q    <= 8'h00;
      byte_q     <= 8'h00;
      txd_q      <= 1'b1;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      char_q     <= char_d;
      shift_q    <= shift_d;
      byte_q     <= byte_d;
      txd_q      <= txd_d;
    end
  end

  // Storage needs no reset: clearing the pointers discards the contents.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.txd      = txd_q;
  assign bus.full     = full_q;
  assign bus.overflow = overflow_q;
  assign bus.busy     = fifo_nempty || (state_q != IDLE);
endmodule

// File: tb/tb_uart_hex_tx.sv
// Bench for uart_hex_tx: two instances (separator on/off) with a line
// receiver per instance, checked against a hex-rendering byte model.
module tb_uart_hex_tx;
  localparam int CLK_HZ = 1000;
  localparam int BAUD   = 100;
  localparam int DIV    = 10;
  localparam int DEPTH  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_hex_tx_if ifa ();
  uart_hex_tx_if ifb ();

  uart_hex_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH),
                .SEP_EN(1'b1), .SEP_CHAR(8'h20))
    dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));

  uart_hex_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH),
                .SEP_EN(1'b0), .SEP_CHAR(8'h20))
    dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int frame_err = 0;
  logic [7:0] rxa_q[$], rxb_q[$], ea[$], eb[$];
  int rta_q[$], rtb_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic line(input int which);
    return (which == 0) ? ifa.txd : ifb.txd;
  endfunction

  // Samples each frame mid-bit; records the cycle its start bit was first seen.
  task automatic rx_loop(input int which);
    logic [7:0] ch;
    int t;
    forever begin
      @(negedge clk);
      if (line(which) === 1'b0) begin
        t = cyc;
        repeat (DIV / 2) @(negedge clk);
        if (line(which) !== 1'b0) frame_err++;
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          ch[i] = line(which);
        end
        repeat (DIV) @(negedge clk);
        if (line(which) !== 1'b1) frame_err++;
        if (which == 0) begin rxa_q.push_back(ch); rta_q.push_back(t); end
        else            begin rxb_q.push_back(ch); rtb_q.push_back(t); end
      end
    end
  endtask

  initial rx_loop(0);
  initial rx_loop(1);

  function automatic void push_exp(input int which, input logic [7:0] b, input bit sep);
    string hx;
    logic [7:0] c0, c1;
    hx = "0123456789ABCDEF";
    c0 = hx[int'(b[7:4])];
    c1 = hx[int'(b[3:0])];
    if (which == 0) begin
      ea.push_back(c0); ea.push_back(c1);
      if (sep) ea.push_back(8'h20);
    end else begin
      eb.push_back(c0); eb.push_back(c1);
      if (sep) eb.push_back(8'h20);
    end
  endfunction

  task automatic send(input int which, input logic [7:0] b);
    if (which == 0) begin ifa.din = b; ifa.din_valid = 1'b1; end
    else            begin ifb.din = b; ifb.din_valid = 1'b1; end
    @(negedge clk);
    ifa.din_valid = 1'b0;
    ifb.din_valid = 1'b0;
  endtask

  task automatic wait_rx(input int which, input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (((which == 0) ? rxa_q.size() : rxb_q.size()) < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, (((which == 0) ? rxa_q.size() : rxb_q.size()) >= n), 1);
  endtask

  task automatic wait_until(input int target);
    int k;
    k = 0;
    while (cyc < target && k < 100000) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic check_stream(input int which, input string tag);
    if (which == 0) begin
      check({tag, "_len"}, rxa_q.size(), ea.size());
      foreach (ea[i])
        check($sformatf("%s[%0d]", tag, i), (i < rxa_q.size()) ? {24'h0, rxa_q[i]} : 32'hFFFF_FFFF, ea[i]);
      rxa_q.delete(); rta_q.delete(); ea.delete();
    end else begin
      check({tag, "_len"}, rxb_q.size(), eb.size());
      foreach (eb[i])
        check($sformatf("%s[%0d]", tag, i), (i < rxb_q.size()) ? {24'h0, rxb_q[i]} : 32'hFFFF_FFFF, eb[i]);
      rxb_q.delete(); rtb_q.delete(); eb.delete();
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c, t, k;
    logic [7:0] b;
    ifa.din = 8'h00; ifa.din_valid = 1'b0; ifa.host_rdy_n = 1'b1;
    ifb.din = 8'h00; ifb.din_valid = 1'b0; ifb.host_rdy_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_txd", ifa.txd, 1);
    check("rst_full", ifa.full, 0);
    check("rst_overflow", ifa.overflow, 0);
    check("rst_busy", ifa.busy, 0);
    check("rst_txd_b", ifb.txd, 1);
    rst = 1'b0;
    ifa.host_rdy_n = 1'b0;
    ifb.host_rdy_n = 1'b0;
    repeat (4) @(negedge clk);

    // Single byte with separator
    c = cyc;
    send(0, 8'h3A);
    push_exp(0, 8'h3A, 1'b1);
    check("single_busy_after_write", ifa.busy, 1);
    wait_rx(0, 3, 400, "single_rx");
    check("single_start_time", rta_q[0], c + 3);
    check("single_char1_time", rta_q[1], c + 3 + 10 * DIV);
    check("single_char2_time", rta_q[2], c + 3 + 20 * DIV);
    t = rta_q[2];
    wait_until(t + 10 * DIV - 1);
    check("single_busy_last_stop", ifa.busy, 1);
    @(negedge clk);
    check("single_busy_drop", ifa.busy, 0);
    check("single_txd_idle", ifa.txd, 1);
    check_stream(0, "single");

    // Hex coverage without separator
    c = cyc;
    send(1, 8'h00); push_exp(1, 8'h00, 1'b0);
    send(1, 8'h9F); push_exp(1, 8'h9F, 1'b0);
    send(1, 8'hFF); push_exp(1, 8'hFF, 1'b0);
    wait_rx(1, 6, 1000, "hex_rx");
    check("hex_start_time", rtb_q[0], c + 3);
    check("hex_char_gap", rtb_q[1] - rtb_q[0], 10 * DIV);
    check("hex_byte_gap1", rtb_q[2] - rtb_q[1], 10 * DIV + 1);
    check("hex_byte_gap2", rtb_q[4] - rtb_q[3], 10 * DIV + 1);
    check_stream(1, "hex");

    // Overflow with the host held off, then a write coinciding with the first pop
    ifa.host_rdy_n = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      send(0, b);
      push_exp(0, b, 1'b1);
      if (i == DEPTH - 2) check("ovf_not_full_15", ifa.full, 0);
    end
    check("ovf_full_16", ifa.full, 1);
    check("ovf_no_pulse_16", ifa.overflow, 0);
    send(0, 8'($urandom));
    check("ovf_pulse", ifa.overflow, 1);
    @(negedge clk);
    check("ovf_pulse_end", ifa.overflow, 0);
    check("ovf_still_full", ifa.full, 1);
    repeat (20) @(negedge clk);
    check("ovf_held_no_tx", rxa_q.size(), 0);
    check("ovf_held_busy", ifa.busy, 1);
    c = cyc;
    ifa.host_rdy_n = 1'b0;
    wait_until(c + 3);
    b = 8'($urandom);
    send(0, b);
    push_exp(0, b, 1'b1);
    check("sim_no_overflow", ifa.overflow, 0);
    check("sim_full", ifa.full, 1);
    wait_rx(0, 3 * (DEPTH + 1), (DEPTH + 1) * (30 * DIV + 1) + 200, "sim_rx");
    check_stream(0, "ovf_sim");
    repeat (10) @(negedge clk);
    check("sim_drained_full", ifa.full, 0);
    check("sim_drained_busy", ifa.busy, 0);

    // Flow control at byte boundaries
    send(0, 8'hA5); push_exp(0, 8'hA5, 1'b1);
    b = 8'($urandom);
    send(0, b); push_exp(0, b, 1'b1);
    k = 0;
    while (ifa.txd !== 1'b0 && k < 50) begin @(negedge clk); k++; end
    check("fc_first_start", ifa.txd, 0);
    ifa.host_rdy_n = 1'b1;
    wait_rx(0, 3, 400, "fc_first_byte");
    repeat (300) @(negedge clk);
    check("fc_held_count", rxa_q.size(), 3);
    check("fc_held_busy", ifa.busy, 1);
    c = cyc;
    ifa.host_rdy_n = 1'b0;
    wait_rx(0, 6, 400, "fc_resume_rx");
    t = (rta_q.size() > 3) ? rta_q[3] : 0;
    check("fc_resume_latency", (t >= c + 3) && (t <= c + 5), 1);
    check_stream(0, "fc");

    // Reset in the middle of a data bit with a full FIFO
    c = cyc;
    send(0, 8'h3C);
    for (int i = 0; i < DEPTH; i++) send(0, 8'($urandom));
    check("rstmid_full_before", ifa.full, 1);
    wait_until(c + 38);
    check("rstmid_txd_low_before", ifa.txd, 0);
    rst = 1'b1;
    #1;
    check("rstmid_txd", ifa.txd, 1);
    check("rstmid_busy", ifa.busy, 0);
    check("rstmid_full", ifa.full, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (110) @(negedge clk);
    rxa_q.delete(); rta_q.delete(); ea.delete();
    b = 8'($urandom);
    send(0, b); push_exp(0, b, 1'b1);
    wait_rx(0, 3, 400, "post_rst_rx");
    check_stream(0, "post_rst");

    check("frame_errors", frame_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_hex_tx.md
# uart_hex_tx

Downstream stage of the accelerometer command-control path. Accepts echoed and SPI-read bytes as single-cycle strobes, buffers them in a FIFO, and renders each byte on the UART TXD line as two uppercase ASCII hex characters plus an optional separator. Framing is 8N1 with host flow control. Replaces the raw byte transmit path so a terminal shows readable register dumps; it absorbs back-to-back strobes that the command logic can issue faster than the line drains.

## Interface
- CLK_HZ, 100_000_000, system clock frequency in Hz
- BAUD, 115200, line rate; bit period DIV = CLK_HZ/BAUD (integer, truncated; 868 at defaults); DIV ≥ 2 required
- FIFO_DEPTH, 16, byte entries; power of 2, ≥ 2
- SEP_EN, 1, 1 = emit SEP_CHAR after each byte's two hex chars
- SEP_CHAR, 8'h20, separator character
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- din  input  8  byte to transmit
- din_valid  input  1  1-cycle write strobe
- host_rdy_n  input  1  host ready to receive, active-low, asynchronous to clk
- txd  output  1  serial data, idle high
- full  output  1  FIFO holds FIFO_DEPTH entries
- overflow  output  1  1-cycle pulse: write dropped
- busy  output  1  FIFO non-empty or a character in flight

## Operation
- Reset values: txd=1, full=0, overflow=0, busy=0; FIFO empty; FSM in IDLE; synchronizer flops=1 (not ready).
- host_rdy_n passes through a 2-flop synchronizer; FSM uses only the synchronized value (rdy_s).
- FIFO: write when din_valid && (!full || pop in same cycle). Write when full with no simultaneous pop is dropped and pulses overflow for exactly 1 cycle. Pointers wrap modulo FIFO_DEPTH. full/count are registered and exact.
- FSM states: IDLE, POP, START, DATA, STOP.
  - IDLE: txd=1. Go to POP when FIFO non-empty && rdy_s==0.
  - POP: txd=1 for exactly 1 cycle; dequeue byte; char index=0; load shift register with hex(byte[7:4]).
  - START: txd=0 for DIV cycles.
  - DATA: 8 bits, LSB first, DIV cycles each.
  - STOP: txd=1 for DIV cycles. Then:
    - if a further char remains for this byte (low nibble, then SEP_CHAR if SEP_EN), load it and go directly to START with no gap;
    - else go to POP if FIFO non-empty && rdy_s==0, else IDLE.
- Hex map: 0–9 → 8'h30–8'h39, A–F → 8'h41–8'h46 (uppercase).
- Flow control is checked only at byte boundaries (IDLE/end of last STOP). A byte already started always finishes all of its chars.
- Baud counter restarts at 0 at each START entry; no fractional accumulation.
- busy = FIFO non-empty || FSM ≠ IDLE.
- Async reset mid-character: txd goes to 1 immediately, and the FIFO contents are discarded.

## Timing
- Write latency: din_valid sampled at edge N; the entry is visible (busy=1) after edge N.
- Idle start: with rdy_s already 0 and the FSM in IDLE, POP is the cycle after edge N and the txd start bit begins at edge N+2.
- Per char: 10·DIV cycles. Per byte: 1 + 20·DIV cycles (SEP_EN=0) or 1 + 30·DIV cycles (SEP_EN=1).
- host_rdy_n assert-to-effect: 2–3 cycles via the synchronizer.
- full rises the edge the FIFO_DEPTH-th entry is written and falls the edge of the next pop.

## Test plan
Bench uses CLK_HZ=1000, BAUD=100, so DIV=10.
- Single byte: host_rdy_n=0, din=8'h3A -> txd frames 8'h33, 8'h41, 8'h20 (back-to-back, 300 cycles); start bit at edge N+2; busy drops after the last stop bit.
- Hex coverage: bytes 8'h00, 8'h9F, 8'hFF, SEP_EN=0 -> "00", "9F", "FF"; 1 idle cycle between bytes; no separators.
- Overflow: host_rdy_n=1, 17 consecutive strobes -> full=1 after the 16th, 17th dropped with a 1-cycle overflow pulse; after release, exactly 16 bytes come out in order.
- Simultaneous: FIFO full, din_valid coincides with POP -> accepted, no overflow; order preserved.
- Flow control: host_rdy_n raised during 8'hA5's first char -> "A5 " completes; next queued byte is held until host_rdy_n=0, then resumes within 3 cycles + POP.
- Reset mid-DATA bit -> txd=1 the same cycle, busy=0, full=0; a byte written after reset transmits correctly.
